// File: rtl/vend_fsm_param.sv
// Parameterised vending controller: collects coins up to MAX_CREDIT, vends at PRICE,
// then pays back any remainder one greedy coin at a time over a valid/ack handshake.
module vend_fsm_param #(
  parameter int PRICE      = 4,
  parameter int VAL_H      = 2,
  parameter int VAL_P      = 4,
  parameter int MAX_CREDIT = 8,
  parameter int CREDIT_W   = 4
) (
  input  logic                CLK,
  input  logic                Reset,
  input  logic                P1,
  input  logic                H50,
  input  logic                F25,
  input  logic                Cancel,
  input  logic                ItemAck,
  input  logic                ChgAck,
  output logic                Item,
  output logic                ChgValid,
  output logic [1:0]          ChgCoin,
  output logic [CREDIT_W-1:0] Credit,
  output logic                Reject,
  output logic [1:0]          OState
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'b00,
    S_COLLECT = 2'b01,
    S_VEND    = 2'b10,
    S_CHANGE  = 2'b11
  } state_t;

  localparam logic [31:0]         L_MAX   = 32'(MAX_CREDIT);
  localparam logic [31:0]         L_VH    = 32'(VAL_H);
  localparam logic [31:0]         L_VP    = 32'(VAL_P);
  localparam logic [CREDIT_W-1:0] L_PRICE = CREDIT_W'(PRICE);

  if (PRICE < 1 || PRICE > MAX_CREDIT ||
      longint'(MAX_CREDIT) >= (longint'(1) << CREDIT_W) ||
      VAL_H <= 1 || VAL_P <= VAL_H) begin : g_param_check
    $error("vend_fsm_param: illegal parameter combination");
  end

  state_t              r_state, w_state_nxt;
  logic [CREDIT_W-1:0] r_credit, w_credit_nxt;
  logic                r_reject, w_reject_nxt;

  logic        w_coin_any, w_coin_multi, w_coin_fits;
  logic [31:0] w_credit32, w_coin_val, w_sum, w_chg_val;
  logic [1:0]  w_chg_code;

  // Arithmetic is done 32 bits wide so a large coin cannot wrap the credit compare.
  assign w_credit32   = 32'(r_credit);
  assign w_coin_any   = P1 | H50 | F25;
  assign w_coin_multi = (P1 & H50) | (P1 & F25) | (H50 & F25);
  assign w_coin_val   = P1 ? L_VP : (H50 ? L_VH : 32'd1);
  assign w_sum        = w_credit32 + w_coin_val;
  assign w_coin_fits  = (w_sum <= L_MAX);

  // Greedy change coin: largest coin that does not exceed the remaining credit.
  always_comb begin
    w_chg_code = 2'b01;
    w_chg_val  = 32'd1;
    if (w_credit32 >= L_VP) begin
      w_chg_code = 2'b11;
      w_chg_val  = L_VP;
    end else if (w_credit32 >= L_VH) begin
      w_chg_code = 2'b10;
      w_chg_val  = L_VH;
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state  <= S_IDLE;
      r_credit <= '0;
      r_reject <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_credit <= w_credit_nxt;
      r_reject <= w_reject_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_reject_nxt = 1'b0;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        if (r_state == S_COLLECT && Cancel) begin
          w_state_nxt  = S_CHANGE;
          w_reject_nxt = w_coin_any;
        end else if (w_coin_any) begin
          if (w_coin_fits) begin
            w_credit_nxt = w_sum[CREDIT_W-1:0];
            w_reject_nxt = w_coin_multi;
            w_state_nxt  = (w_sum[CREDIT_W-1:0] >= L_PRICE) ? S_VEND : S_COLLECT;
          end else begin
            w_reject_nxt = 1'b1;
          end
        end
      end
      S_VEND: begin
        w_reject_nxt = w_coin_any;
        if (ItemAck) begin
          w_credit_nxt = r_credit - L_PRICE;
          w_state_nxt  = (r_credit == L_PRICE) ? S_IDLE : S_CHANGE;
        end
      end
      S_CHANGE: begin
        w_reject_nxt = w_coin_any;
        if (ChgAck) begin
          w_credit_nxt = r_credit - w_chg_val[CREDIT_W-1:0];
          w_state_nxt  = (w_credit32 == w_chg_val) ? S_IDLE : S_CHANGE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    Item     = (r_state == S_VEND);
    ChgValid = (r_state == S_CHANGE);
    ChgCoin  = (r_state == S_CHANGE) ? w_chg_code : 2'b00;
    Credit   = r_credit;
    Reject   = r_reject;
    OState   = r_state;
  end

endmodule

// File: tb/tb_vend_fsm_param.sv
// Bench for vend_fsm_param: two instances (PRICE 4 and PRICE 7) share one input stream;
// each has a behavioural model feeding an expected queue drained by a monitor.
module tb_vend_fsm_param;

  localparam int MAXC = 8;
  localparam int VP   = 4;
  localparam int VH   = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1, p1 = 1'b0, h50 = 1'b0, f25 = 1'b0;
  logic cancel = 1'b0, iack = 1'b0, cack = 1'b0;

  logic       a_item, a_cv, a_rej, b_item, b_cv, b_rej;
  logic [1:0] a_coin, a_st, b_coin, b_st;
  logic [3:0] a_credit, b_credit;

  vend_fsm_param dut_a (
    .CLK(clk), .Reset(rst), .P1(p1), .H50(h50), .F25(f25), .Cancel(cancel),
    .ItemAck(iack), .ChgAck(cack), .Item(a_item), .ChgValid(a_cv), .ChgCoin(a_coin),
    .Credit(a_credit), .Reject(a_rej), .OState(a_st)
  );

  vend_fsm_param #(.PRICE(7), .VAL_H(2), .VAL_P(4), .MAX_CREDIT(8), .CREDIT_W(4)) dut_b (
    .CLK(clk), .Reset(rst), .P1(p1), .H50(h50), .F25(f25), .Cancel(cancel),
    .ItemAck(iack), .ChgAck(cack), .Item(b_item), .ChgValid(b_cv), .ChgCoin(b_coin),
    .Credit(b_credit), .Reject(b_rej), .OState(b_st)
  );

  int checks   = 0;
  int failures = 0;

  logic [10:0] exp_q_a[$];
  logic [10:0] exp_q_b[$];

  // Model: mode 0 idle, 1 collecting, 2 vending, 3 paying change.
  int m_mode[2];
  int m_credit[2];
  bit m_rej[2];
  int m_price[2] = '{4, 7};

  function automatic int chg_val(int c);
    if (c >= VP) return VP;
    if (c >= VH) return VH;
    return 1;
  endfunction

  function automatic logic [1:0] chg_code(int c);
    if (c >= VP) return 2'b11;
    if (c >= VH) return 2'b10;
    return 2'b01;
  endfunction

  task automatic model_step(input int k);
    int n, v;
    n = int'(p1) + int'(h50) + int'(f25);
    if (rst) begin
      m_mode[k] = 0; m_credit[k] = 0; m_rej[k] = 0;
      return;
    end
    m_rej[k] = 0;
    if (m_mode[k] <= 1) begin
      if (m_mode[k] == 1 && cancel) begin
        m_mode[k] = 3;
        m_rej[k]  = (n > 0);
      end else if (n > 0) begin
        v = p1 ? VP : (h50 ? VH : 1);
        if (m_credit[k] + v <= MAXC) begin
          m_credit[k] += v;
          m_rej[k]  = (n > 1);
          m_mode[k] = (m_credit[k] >= m_price[k]) ? 2 : 1;
        end else begin
          m_rej[k] = 1;
        end
      end
    end else if (m_mode[k] == 2) begin
      m_rej[k] = (n > 0);
      if (iack) begin
        m_credit[k] -= m_price[k];
        m_mode[k] = (m_credit[k] > 0) ? 3 : 0;
      end
    end else begin
      m_rej[k] = (n > 0);
      if (cack) begin
        m_credit[k] -= chg_val(m_credit[k]);
        m_mode[k] = (m_credit[k] == 0) ? 0 : 3;
      end
    end
  endtask

  function automatic logic [10:0] model_obs(input int k);
    logic [1:0] coin;
    coin = (m_mode[k] == 3) ? chg_code(m_credit[k]) : 2'b00;
    return {2'(m_mode[k]), 4'(m_credit[k]), m_mode[k] == 2, m_mode[k] == 3, coin, m_rej[k]};
  endfunction

  // Driver: inputs change on the falling edge; the expected post-edge outputs are queued.
  task automatic drive(input bit r, input bit c_p, input bit c_h, input bit c_f,
                       input bit c_can, input bit c_ia, input bit c_ca);
    @(negedge clk);
    rst = r; p1 = c_p; h50 = c_h; f25 = c_f; cancel = c_can; iack = c_ia; cack = c_ca;
    for (int k = 0; k < 2; k++) model_step(k);
    exp_q_a.push_back(model_obs(0));
    exp_q_b.push_back(model_obs(1));
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every registered cycle produces an observable output vector per instance.
  initial begin
    logic [10:0] e, act;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q_a.size() > 0) begin
        e   = exp_q_a.pop_front();
        act = {a_st, a_credit, a_item, a_cv, a_coin, a_rej};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL dut_a_obs t=%0t actual=%b expected=%b (state,credit,item,cv,coin,rej)", $time, act, e);
        end
      end
      if (exp_q_b.size() > 0) begin
        e   = exp_q_b.pop_front();
        act = {b_st, b_credit, b_item, b_cv, b_coin, b_rej};
        checks++;
        if (act !== e) begin
          failures++;
          $display("FAIL dut_b_obs t=%0t actual=%b expected=%b (state,credit,item,cv,coin,rej)", $time, act, e);
        end
      end
    end
  end

  initial begin
    // Reset state
    drive(1, 0, 0, 0, 0, 0, 0); settle;
    chk("rst_state", a_st, 0); chk("rst_credit", a_credit, 0);
    chk("rst_cv", a_cv, 0); chk("rst_item", a_item, 0);

    // F25, H50, F25 -> 1, 3, 4 then vend; ItemAck -> idle
    drive(0, 0, 0, 1, 0, 0, 0); settle; chk("s1_credit1", a_credit, 1);
    drive(0, 0, 1, 0, 0, 0, 0); settle; chk("s1_credit3", a_credit, 3);
    drive(0, 0, 0, 1, 0, 0, 0); settle; chk("s1_credit4", a_credit, 4);
    chk("s1_item", a_item, 1);
    drive(0, 0, 0, 0, 0, 1, 0); settle;
    chk("s1_ack_credit", a_credit, 0); chk("s1_ack_state", a_st, 0);

    // H50 then P1 -> 6, vend; ItemAck -> change with H50; ChgAck -> idle
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0); settle;
    chk("s2_credit6", a_credit, 6); chk("s2_vend", a_st, 2);
    drive(0, 0, 0, 0, 0, 1, 0); settle;
    chk("s2_change", a_st, 3); chk("s2_coin", a_coin, 2);
    drive(0, 0, 0, 0, 0, 0, 1); settle;
    chk("s2_idle", a_st, 0); chk("s2_credit0", a_credit, 0);

    // F25, F25, Cancel+P1 -> reject, change with H50; ChgAck -> idle
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0, 0); settle;
    chk("s3_reject", a_rej, 1); chk("s3_change", a_st, 3);
    chk("s3_coin", a_coin, 2); chk("s3_credit", a_credit, 2);
    drive(0, 0, 0, 0, 0, 0, 1); settle;
    chk("s3_idle", a_st, 0);

    // All three coins at once from idle
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 1, 1, 0, 0, 0); settle;
    chk("s4_credit", a_credit, 4); chk("s4_reject", a_rej, 1); chk("s4_item", a_item, 1);
    drive(0, 0, 0, 0, 0, 0, 0); settle;
    chk("s4_reject_pulse", a_rej, 0);

    // PRICE 7 instance: credit 6 + P1 rejected, F25 -> 7 and vend
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 1, 0, 0, 0, 0); settle; chk("s5_credit6", b_credit, 6);
    drive(0, 1, 0, 0, 0, 0, 0); settle;
    chk("s5_reject", b_rej, 1); chk("s5_hold6", b_credit, 6);
    drive(0, 0, 0, 1, 0, 0, 0); settle;
    chk("s5_credit7", b_credit, 7); chk("s5_vend", b_st, 2);

    // Reset in the middle of paying change, then a stray ChgAck
    drive(1, 0, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 1, 0); settle;
    chk("s6_change", a_st, 3); chk("s6_credit3", a_credit, 3);
    drive(1, 0, 0, 0, 0, 0, 0); settle;
    chk("s6_rst_state", a_st, 0); chk("s6_rst_credit", a_credit, 0); chk("s6_rst_cv", a_cv, 0);
    drive(0, 0, 0, 0, 0, 0, 1); settle;
    chk("s6_stray_ack", a_credit, 0); chk("s6_stray_state", a_st, 0);

    // Randomised traffic, checked by the monitor against the model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 63) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
            $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 2) == 0);
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("drain_a", exp_q_a.size(), 0);
    chk("drain_b", exp_q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
